// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_pkg
// Description : Shared constants and width helpers for the UART FIFO and the
//               TX/RX wrappers that size their ports from it.
//                 UART_FIFO_DEF_WIDTH : default data word width (8)
//                 UART_FIFO_DEF_DEPTH : default number of entries (16)
//                 uart_fifo_ptr_w()   : pointer width for a given depth
//                 uart_fifo_cnt_w()   : occupancy width for a given depth
//                 ptr_t / count_t     : typedefs sized for the default depth
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_fifo_pkg;

    localparam int UART_FIFO_DEF_WIDTH = 8;
    localparam int UART_FIFO_DEF_DEPTH = 16;

    // Pointer width; a depth of 1 would give $clog2 = 0, so clamp to 1 bit.
    function automatic int uart_fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int uart_fifo_cnt_w(input int depth);
        return uart_fifo_ptr_w(depth) + 1;
    endfunction

    typedef logic [uart_fifo_ptr_w(UART_FIFO_DEF_DEPTH)-1:0] ptr_t;
    typedef logic [uart_fifo_cnt_w(UART_FIFO_DEF_DEPTH)-1:0] count_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : Simple dual-port DEPTH x WIDTH register array.
//               One synchronous write port, one combinational read port.
//   Ports:
//     clk      : clock
//     i_we     : write enable
//     i_waddr  : write address
//     i_wdata  : write data
//     i_raddr  : read address
//     o_rdata  : read data (combinational from i_raddr)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = UART_FIFO_DEF_WIDTH,
    parameter int DEPTH = UART_FIFO_DEF_DEPTH,
    localparam int AW   = uart_fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Contents are deliberately not reset: the top never reads an entry it
    // has not written since the last reset/flush.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_param
// Description : Parametrised FIFO for the UART TX/RX datapaths with occupancy
//               count, threshold trigger, synchronous flush and sticky
//               overrun/underrun flags.
//               Build option: define UART_FIFO_FWFT_EN for first-word-fall-
//               through reads (dout = head word, no output register).
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     en          : gates push_in / pop_in
//     push_in     : write request, din captured when accepted
//     pop_in      : read request
//     flush       : synchronous empty (ignores en)
//     err_clr     : clears overrun / underrun
//     din         : write data
//     thres_hold  : trigger level 0..DEPTH (0 disables)
//     dout        : read data
//     empty, full : occupancy status
//     count       : occupancy 0..DEPTH
//     thres_trig  : count has reached thres_hold
//     overrun     : sticky, a push was dropped
//     underrun    : sticky, a pop was made while empty
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_fifo_param
    import uart_fifo_pkg::*;
#(
    parameter int WIDTH = UART_FIFO_DEF_WIDTH,
    parameter int DEPTH = UART_FIFO_DEF_DEPTH,
    localparam int AW   = uart_fifo_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic             flush,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] din,
    input  logic [AW:0]      thres_hold,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             thres_trig,
    output logic             overrun,
    output logic             underrun
);

    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overrun;
    logic             r_underrun;

    logic             w_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop_req;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_set_ovr;
    logic             w_set_udr;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_rd_data;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_COUNT);

    assign w_push_req = en & push_in;
    assign w_pop_req  = en & pop_in;
    assign w_pop_ok   = w_pop_req & ~w_empty;
    // A full FIFO still takes a push when the same-cycle pop frees a slot.
    assign w_push_ok  = w_push_req & (~w_full | w_pop_ok);

    // Errors are suppressed in a flush cycle: flush discards the requests.
    assign w_set_ovr  = w_push_req & ~w_push_ok & ~flush;
    assign w_set_udr  = w_pop_req & w_empty & ~flush;

    assign w_mem_we   = w_push_ok & ~flush & ~rst;

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error in the same cycle as err_clr wins, so the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= (r_overrun  & ~err_clr) | w_set_ovr;
            r_underrun <= (r_underrun & ~err_clr) | w_set_udr;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head word is presented directly; undefined while empty.
    assign dout = w_rd_data;
`else
    logic [WIDTH-1:0] r_dout;

    // When full with a simultaneous push, wr_ptr == rd_ptr; the read sees the
    // old word because the array write lands at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_pop_ok && !flush) begin
            r_dout <= w_rd_data;
        end
    end

    assign dout = r_dout;
`endif

    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;
    assign thres_trig = (thres_hold != '0) && (r_count >= thres_hold);
    assign overrun    = r_overrun;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_param
// Description : Self-checking bench for uart_fifo_param (WIDTH=8, DEPTH=16).
//               A queue-based model tracks the FIFO contents and flags; a
//               negedge process compares every output against it, and the
//               directed scenarios pin the model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             push_in;
    logic             pop_in;
    logic             flush;
    logic             err_clr;
    logic [WIDTH-1:0] din;
    logic [AW:0]      thres_hold;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             thres_trig;
    logic             overrun;
    logic             underrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_fifo_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .push_in    (push_in),
        .pop_in     (pop_in),
        .flush      (flush),
        .err_clr    (err_clr),
        .din        (din),
        .thres_hold (thres_hold),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .thres_trig (thres_trig),
        .overrun    (overrun),
        .underrun   (underrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    bit               m_ovr  = 1'b0;
    bit               m_udr  = 1'b0;
    bit               m_started = 1'b0;

    always @(posedge clk) begin
        bit pop_ok, push_ok, new_ovr, new_udr;
        m_started = 1'b1;
        if (rst) begin
            m_q.delete();
            m_dout = '0;
            m_ovr  = 1'b0;
            m_udr  = 1'b0;
        end else if (flush) begin
            m_q.delete();
            if (err_clr) begin
                m_ovr = 1'b0;
                m_udr = 1'b0;
            end
        end else begin
            pop_ok  = en && pop_in && (m_q.size() > 0);
            push_ok = en && push_in && ((m_q.size() < DEPTH) || pop_ok);
            new_ovr = en && push_in && !push_ok;
            new_udr = en && pop_in && (m_q.size() == 0);
            if (pop_ok)  m_dout = m_q.pop_front();
            if (push_ok) m_q.push_back(din);
            if (err_clr) begin
                m_ovr = 1'b0;
                m_udr = 1'b0;
            end
            if (new_ovr) m_ovr = 1'b1;
            if (new_udr) m_udr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            int n;
            n = m_q.size();
            chk("m_count",    int'(count),      n);
            chk("m_empty",    int'(empty),      int'(n == 0));
            chk("m_full",     int'(full),       int'(n == DEPTH));
            chk("m_thres",    int'(thres_trig), int'((thres_hold != 0) && (n >= int'(thres_hold))));
            chk("m_overrun",  int'(overrun),    int'(m_ovr));
            chk("m_underrun", int'(underrun),   int'(m_udr));
`ifdef UART_FIFO_FWFT_EN
            if (n > 0) chk("m_dout", int'(dout), int'(m_q[0]));
`else
            chk("m_dout", int'(dout), int'(m_dout));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit q, input logic [WIDTH-1:0] d);
        rst = 0; en = 1; flush = 0; err_clr = 0;
        push_in = p; pop_in = q; din = d;
        tick();
    endtask

    logic [WIDTH-1:0] bytes_a [20];
    logic [WIDTH-1:0] seq     [16];

    initial begin
        rst = 1; en = 1; push_in = 1; pop_in = 0; flush = 0; err_clr = 0;
        din = 8'h3C; thres_hold = 5'd10;

        // Reset held with push asserted.
        for (int i = 0; i < 5; i++) tick();
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_dout",  int'(dout),  0);
        chk("rst_ovr",   int'(overrun), 0);
        chk("rst_udr",   int'(underrun), 0);
        chk("rst_thr",   int'(thres_trig), 0);

        // Fill and overflow.
        for (int i = 0; i < 20; i++) begin
            bytes_a[i] = 8'($urandom);
            drive(1, 0, bytes_a[i]);
            chk("fill_count", int'(count), (i < 16) ? i + 1 : 16);
            if (i == 8)  chk("fill_thr9",   int'(thres_trig), 0);
            if (i == 9)  chk("fill_thr10",  int'(thres_trig), 1);
            if (i == 14) chk("fill_full15", int'(full), 0);
            if (i == 15) chk("fill_full16", int'(full), 1);
            if (i == 15) chk("fill_ovr16",  int'(overrun), 0);
            if (i == 16) chk("fill_ovr17",  int'(overrun), 1);
        end

        // Drain and underflow.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 8'h00);
`ifdef UART_FIFO_FWFT_EN
            if (i < 15) chk("drain_dout", int'(dout), int'(bytes_a[i+1]));
`else
            if (i < 16) chk("drain_dout", int'(dout), int'(bytes_a[i]));
`endif
            if (i == 14) chk("drain_empty15", int'(empty), 0);
            if (i == 15) chk("drain_empty16", int'(empty), 1);
            if (i == 15) chk("drain_udr16",   int'(underrun), 0);
            if (i == 16) chk("drain_udr17",   int'(underrun), 1);
        end
        rst = 0; push_in = 0; pop_in = 0; err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_udr", int'(underrun), 0);

        // Simultaneous push/pop at full.
        for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'(8'h80 + i));
            chk("sim_full_count", int'(count), 16);
            chk("sim_full_ovr",   int'(overrun), 0);
        end
        for (int i = 0; i < 16; i++) seq[i] = (i < 12) ? 8'(8'h14 + i) : 8'(8'h80 + i - 12);
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 8'h00);
`ifdef UART_FIFO_FWFT_EN
            if (i < 15) chk("sim_full_order", int'(dout), int'(seq[i+1]));
`else
            chk("sim_full_order", int'(dout), int'(seq[i]));
`endif
        end

        // Simultaneous push/pop at empty.
        drive(1, 1, 8'h5C);
        chk("sim_empty_count", int'(count), 1);
        chk("sim_empty_udr",   int'(underrun), 1);

        // Wrap-around at constant occupancy 3.
        drive(1, 0, 8'h61);
        drive(1, 0, 8'h62);
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 8'($urandom));
            chk("wrap_count", int'(count), 3);
        end

        // Flush with push asserted; flags untouched.
        rst = 0; en = 1; push_in = 1; pop_in = 0; flush = 1; din = 8'hEE;
        tick();
        flush = 0; push_in = 0;
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_udr",   int'(underrun), 1);
        chk("flush_ovr",   int'(overrun), 0);

        // Single push into an empty FIFO.
        drive(1, 0, 8'hA5);
        chk("one_count", int'(count), 1);
`ifdef UART_FIFO_FWFT_EN
        chk("fwft_dout", int'(dout), 8'hA5);
`endif

        // Randomised traffic, biased alternately toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias       = ((i / 150) % 2 == 0) ? 75 : 25;
            rst        = ($urandom_range(0, 399) == 0);
            en         = ($urandom_range(0, 9) != 0);
            flush      = ($urandom_range(0, 99) == 0);
            err_clr    = ($urandom_range(0, 29) == 0);
            push_in    = ($urandom_range(0, 99) < bias);
            pop_in     = ($urandom_range(0, 99) >= bias);
            if ($urandom_range(0, 3) == 0) pop_in = push_in;
            din        = 8'($urandom);
            if (i % 50 == 0) thres_hold = 5'($urandom_range(0, 18));
            tick();
        end

        rst = 0; push_in = 0; pop_in = 0; flush = 0; err_clr = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
